// File: rtl/full_sub_reg_pkg.sv
// full_sub_reg_pkg
//   Shared constants for the registered ripple-borrow subtractor slice.
//   FSR_DEFAULT_WIDTH : default operand/difference width (classic 1-bit cell).
package full_sub_reg_pkg;

  localparam int unsigned FSR_DEFAULT_WIDTH = 1;

endpackage : full_sub_reg_pkg

// File: rtl/full_sub_reg_if.sv
// full_sub_reg_if
//   Operand/result bundle for full_sub_reg.
//   IN_VALID, A, B, B_I     : operands, driven by the master side.
//   OUT_VALID, D, B_O       : registered result, driven by the slave (subtractor).
//   master modport : producer of operands / consumer of results.
//   slave modport  : the subtractor itself.
interface full_sub_reg_if
  import full_sub_reg_pkg::*;
#(
  parameter int unsigned WIDTH = FSR_DEFAULT_WIDTH
);

  logic             IN_VALID;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             B_I;
  logic             OUT_VALID;
  logic [WIDTH-1:0] D;
  logic             B_O;

  modport master (
    output IN_VALID, A, B, B_I,
    input  OUT_VALID, D, B_O
  );

  modport slave (
    input  IN_VALID, A, B, B_I,
    output OUT_VALID, D, B_O
  );

endinterface : full_sub_reg_if

// File: rtl/full_sub_bit.sv
// full_sub_bit
//   Combinational single-bit full subtractor cell: d = a - b - bin.
//   a, b  : minuend / subtrahend bit
//   bin   : borrow in
//   d     : difference bit
//   bout  : borrow out (set when a < b + bin)
module full_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_sub_bit

// File: rtl/full_sub_reg.sv
// full_sub_reg
//   Registered WIDTH-bit ripple-borrow subtractor: {B_O, D} = A - B - B_I.
//   CLK   : system clock, all state on rising edge
//   RST_N : synchronous active-low reset (clears D, B_O, OUT_VALID)
//   bus   : operand/result bundle (slave side)
//           IN_VALID/A/B/B_I in; OUT_VALID/D/B_O out, one cycle latency.
//   D and B_O hold their last value when no operand is presented;
//   OUT_VALID marks only freshly computed results.
module full_sub_reg
  import full_sub_reg_pkg::*;
#(
  parameter int unsigned WIDTH = FSR_DEFAULT_WIDTH
) (
  input  logic           CLK,
  input  logic           RST_N,
  full_sub_reg_if.slave  bus
);

  logic [WIDTH:0]   w_borrow;
  logic [WIDTH-1:0] w_diff;

  logic [WIDTH-1:0] r_d;
  logic             r_b_o;
  logic             r_out_valid;

  assign w_borrow[0] = bus.B_I;

  // Borrow ripples LSB to MSB; each cell feeds the next cell's bin.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    full_sub_bit u_bit (
      .a    (bus.A[gi]),
      .b    (bus.B[gi]),
      .bin  (w_borrow[gi]),
      .d    (w_diff[gi]),
      .bout (w_borrow[gi+1])
    );
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_d         <= '0;
      r_b_o       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.IN_VALID;
      if (bus.IN_VALID) begin
        r_d   <= w_diff;
        r_b_o <= w_borrow[WIDTH];
      end
    end
  end

  assign bus.D         = r_d;
  assign bus.B_O       = r_b_o;
  assign bus.OUT_VALID = r_out_valid;

endmodule : full_sub_reg

// File: tb/tb_full_sub_reg.sv
// tb_full_sub_reg
//   Self-checking bench for full_sub_reg at WIDTH=1 and WIDTH=8 side by side.
//   A behavioural model computes each expected result with plain integer
//   subtraction modulo 2^(WIDTH+1) and tracks hold/valid/reset behaviour.
module tb_full_sub_reg;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  always #5 CLK = ~CLK;

  full_sub_reg_if #(.WIDTH(1)) bus1 ();
  full_sub_reg_if #(.WIDTH(8)) bus8 ();

  full_sub_reg #(.WIDTH(1)) u_dut1 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus1)
  );

  full_sub_reg #(.WIDTH(8)) u_dut8 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus8)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Model state for both instances.
  logic       m1_v, m1_d, m1_bo;
  logic       m8_v, m8_bo;
  logic [7:0] m8_d;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // (A - B - B_I) mod 2^(w+1); bit w is the borrow-out.
  function automatic logic [8:0] ref_sub(input int unsigned w, input logic [7:0] a,
                                         input logic [7:0] b, input logic bi);
    int diff;
    diff = int'(a) - int'(b) - int'(bi);
    return 9'(diff & ((1 << (w + 1)) - 1));
  endfunction

  task automatic model_edge();
    logic [8:0] r;
    if (!RST_N) begin
      m1_v = 1'b0; m1_d = 1'b0; m1_bo = 1'b0;
      m8_v = 1'b0; m8_d = '0;   m8_bo = 1'b0;
    end else begin
      m1_v = bus1.IN_VALID;
      if (bus1.IN_VALID) begin
        r = ref_sub(1, 8'(bus1.A), 8'(bus1.B), bus1.B_I);
        m1_d  = r[0];
        m1_bo = r[1];
      end
      m8_v = bus8.IN_VALID;
      if (bus8.IN_VALID) begin
        r = ref_sub(8, bus8.A, bus8.B, bus8.B_I);
        m8_d  = r[7:0];
        m8_bo = r[8];
      end
    end
  endtask

  // Advance one edge, update the model with the inputs sampled there, compare.
  task automatic tick(input string tag);
    @(posedge CLK);
    #1;
    model_edge();
    check({tag, "/w1.v"},  64'(bus1.OUT_VALID), 64'(m1_v));
    check({tag, "/w1.d"},  64'(bus1.D),         64'(m1_d));
    check({tag, "/w1.bo"}, 64'(bus1.B_O),       64'(m1_bo));
    check({tag, "/w8.v"},  64'(bus8.OUT_VALID), 64'(m8_v));
    check({tag, "/w8.d"},  64'(bus8.D),         64'(m8_d));
    check({tag, "/w8.bo"}, 64'(bus8.B_O),       64'(m8_bo));
  endtask

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic bi);
    bus8.IN_VALID = v; bus8.A = a; bus8.B = b; bus8.B_I = bi;
  endtask

  task automatic drive1(input logic v, input logic a, input logic b, input logic bi);
    bus1.IN_VALID = v; bus1.A = a; bus1.B = b; bus1.B_I = bi;
  endtask

  // WIDTH=1 truth table, index = {A,B,B_I}; expected {D,B_O}.
  logic [1:0] tt_exp [8];

  initial begin
    // (A,B,B_I)         -> (D,B_O)
    tt_exp[3'b000] = 2'b00; tt_exp[3'b100] = 2'b10;
    tt_exp[3'b010] = 2'b11; tt_exp[3'b110] = 2'b00;
    tt_exp[3'b001] = 2'b11; tt_exp[3'b101] = 2'b00;
    tt_exp[3'b011] = 2'b01; tt_exp[3'b111] = 2'b11;

    // Reset held two edges with a valid operand present.
    RST_N = 1'b0;
    drive1(1'b1, 1'b1, 1'b0, 1'b0);
    drive8(1'b1, 8'h01, 8'h00, 1'b0);
    tick("rst0");
    tick("rst1");
    check("rst/d8",  64'(bus8.D),         64'h0);
    check("rst/v8",  64'(bus8.OUT_VALID), 64'h0);
    check("rst/bo1", 64'(bus1.B_O),       64'h0);

    // WIDTH=1 truth table, back-to-back valid.
    #1; RST_N = 1'b1;
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = 3'(i);
      drive1(1'b1, idx[2], idx[1], idx[0]);
      tick($sformatf("tt%0d", i));
      check($sformatf("tt%0d/d", i),  64'(bus1.D),   64'(tt_exp[idx][1]));
      check($sformatf("tt%0d/bo", i), 64'(bus1.B_O), 64'(tt_exp[idx][0]));
    end
    drive1(1'b0, 1'b0, 1'b0, 1'b0);

    // WIDTH=8 wrap and plain borrow across a nibble.
    drive8(1'b1, 8'h00, 8'h00, 1'b1);
    tick("wrap");
    check("wrap/d",  64'(bus8.D),   64'hFF);
    check("wrap/bo", 64'(bus8.B_O), 64'h1);
    drive8(1'b1, 8'h10, 8'h01, 1'b0);
    tick("nib");
    check("nib/d",  64'(bus8.D),   64'h0F);
    check("nib/bo", 64'(bus8.B_O), 64'h0);

    // Hold: result persists, valid drops.
    drive8(1'b1, 8'd5, 8'd3, 1'b0);
    tick("hold0");
    check("hold0/d", 64'(bus8.D),         64'd2);
    check("hold0/v", 64'(bus8.OUT_VALID), 64'd1);
    drive8(1'b0, 8'd9, 8'd3, 1'b0);
    tick("hold1");
    check("hold1/d",  64'(bus8.D),         64'd2);
    check("hold1/bo", 64'(bus8.B_O),       64'd0);
    check("hold1/v",  64'(bus8.OUT_VALID), 64'd0);

    // Mid-stream reset for one edge, then resume.
    for (int i = 0; i < 4; i++) begin
      drive8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      drive1(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
      tick("pre");
    end
    RST_N = 1'b0;
    drive8(1'b1, 8'h77, 8'h11, 1'b0);
    tick("midrst");
    check("midrst/d",  64'(bus8.D),         64'h0);
    check("midrst/bo", 64'(bus8.B_O),       64'h0);
    check("midrst/v",  64'(bus8.OUT_VALID), 64'h0);
    RST_N = 1'b1;
    drive8(1'b1, 8'h77, 8'h11, 1'b0);
    tick("resume");
    check("resume/d", 64'(bus8.D), 64'h66);

    // Random stream: mostly valid, occasional idle cycles.
    for (int i = 0; i < 1000; i++) begin
      drive8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      drive1(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), 1'($urandom));
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_full_sub_reg
